// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/dm_arbiter_if.sv
// Core-side request bus plus shared DM port; slave = arbiter, master = cores/memory.
interface dm_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
);

  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        we;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0]        gnt;
  logic [NUM_CORES-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;
  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        busy;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/dm_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above ptr, wrapping.
// Zero latency; no handshake.
module rr_pick #(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 any,
  output logic [PTR_W-1:0]     winner
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    any    = |req;
    winner = '0;
    idx    = 0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (req[idx]) winner = PTR_W'(idx);
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port DM; read 3 cycles, write 2 cycles per access.
// Requests are sampled only in IDLE; a requester holds its request until gnt.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e                state_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      ptr_d;
  logic [PTR_W-1:0]      win_q;
  logic                  wr_q;
  logic [NUM_CORES-1:0]  gnt_q;
  logic [NUM_CORES-1:0]  rvalid_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;

  logic                  any;
  logic [PTR_W-1:0]      winner;

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .any    (any),
    .winner (winner)
  );

  always_comb begin
    if (int'(winner) == NUM_CORES - 1) ptr_d = '0;
    else                               ptr_d = winner + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      wr_q        <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (any) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.we[winner];
            wr_q        <= bus.we[winner];
            mem_addr_q  <= bus.addr[int'(winner)*ADDR_W +: ADDR_W];
            mem_wdata_q <= bus.wdata[int'(winner)*DATA_W +: DATA_W];
            gnt_q       <= NUM_CORES'(1) << winner;
            win_q       <= winner;
            ptr_q       <= ptr_d;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= wr_q ? IDLE : RESP;
        end
        RESP: begin
          rdata_q  <= bus.mem_rdata;
          rvalid_q <= NUM_CORES'(1) << win_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Round-robin arbiter that shares one single-port synchronous data memory (DM) between `NUM_CORES` processor cores. Each core has its own control unit and datapath but no private DM. The arbiter accepts one request at a time, drives the shared memory port, and returns read data to the winning core with a one-cycle valid pulse. It sits between the per-core DM read/write paths and the DM block instance.

## Interface
- `NUM_CORES`, 4: number of requesting cores, 1..8.
- `ADDR_W`, 16: DM address width; memory depth is 2^ADDR_W.
- `DATA_W`, 16: DM word width.

- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NUM_CORES  per-core access request, level.
- `we`  in  NUM_CORES  per-core write flag (1 = write, 0 = read), qualified by `req`.
- `addr`  in  NUM_CORES*ADDR_W  flattened per-core address; core i at `[i*ADDR_W +: ADDR_W]`.
- `wdata`  in  NUM_CORES*DATA_W  flattened per-core write data.
- `gnt`  out  NUM_CORES  one-hot, one-cycle pulse: request accepted.
- `rvalid`  out  NUM_CORES  one-hot, one-cycle pulse: `rdata` valid for that core.
- `rdata`  out  DATA_W  shared read-data bus.
- `mem_en`, `mem_we`  out  1  DM enable and write strobe.
- `mem_addr`  out  ADDR_W  DM address.
- `mem_wdata`  out  DATA_W  DM write data.
- `mem_rdata`  in  DATA_W  DM read data, valid one cycle after `mem_en` with `mem_we`=0.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE:** on a posedge with any `req` high, select the winner w by round-robin.
  - Latch `addr[w]`, `we[w]` and `wdata[w]` into the `mem_*` registers.
  - Set `mem_en`=1, `mem_we`=`we[w]` and `gnt[w]`=1, then go to ACCESS.
  - If no `req` is high, stay in IDLE.
- **ACCESS:** lasts one cycle. Clear `mem_en`, `mem_we` and `gnt`.
  - For a write, go to IDLE.
  - For a read, go to RESP.
- **RESP:** lasts one cycle. Capture `rdata` <= `mem_rdata`, set `rvalid[w]`=1, then go to IDLE.
  - `rvalid` clears on the next edge.
  - `rdata` holds its value until the next read response.
- **Round-robin pointer `ptr`:**
  - The search starts at `ptr` and ascends modulo NUM_CORES; the first core with `req` high wins.
  - After each grant, `ptr` <= (w+1) mod NUM_CORES.
  - Reset value of `ptr` is 0.
- **Requester rules:**
  - Hold `req`, `we`, `addr` and `wdata` stable until `gnt` is sampled high.
  - Drop `req` after `gnt`, or keep it high to queue another access.
  - `req` is sampled only in IDLE; values in other states are ignored with no penalty.
- Writes produce no `rvalid`; completion is implied by `gnt`.
- **Reset:** asynchronous and honoured mid-operation. All of the following clear immediately and the pending access is dropped, so no partial write can occur:
  - state <= IDLE, `ptr` <= 0;
  - `gnt`, `rvalid`, `mem_en`, `mem_we`, `busy` <= 0;
  - `rdata`, `mem_addr`, `mem_wdata` <= 0.
- NUM_CORES=1 degenerates to a pass-through with the same timing.
- Addresses are not range-checked.

## Timing
- Read: `req` high at edge k (IDLE) -> `gnt`/`mem_en` in cycle k+1 -> `mem_rdata` in cycle k+2 -> `rvalid`/`rdata` in cycle k+3.
  - Next grant no earlier than edge k+3, giving a 3-cycle read throughput.
- Write: `gnt`, `mem_en` and `mem_we` in cycle k+1 only.
  - Next grant at edge k+2, giving a 2-cycle write throughput.
- All outputs are registered; there are no combinational paths from `req` to any output.

## Structure
- Package `dm_arb_pkg` holds:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - default widths ADDR_W=16 and DATA_W=16.
- Sub-module `rr_pick`: combinational round-robin priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: `any`, `winner` index.

## Test plan
- **Single read:** preload mem[0x0010]=0x00AB; core1 reads 0x0010 at edge 0.
  - Expect `gnt`=4'b0010 and `mem_addr`=0x0010 in cycle 1.
  - Expect `rvalid`=4'b0010 and `rdata`=0x00AB in cycle 3.
- **Write then read:** core0 writes 0x1234 to 0x0005, then reads 0x0005.
  - Expect `mem_we` high for exactly cycle 1.
  - The read returns 0x1234.
- **Fairness:** all four cores hold read requests continuously from reset.
  - Expect grants in order 0, 1, 2, 3, 0, one every 3 cycles.
- **Pointer rotation:** after core2 is granted, cores 1 and 3 request together.
  - Expect core3 granted first, then core1.
- **Reset mid-write:** assert `rst` asynchronously during ACCESS of a write.
  - Expect `mem_we`, `mem_en` and `gnt` low immediately and no `rvalid`.
  - After release, cores 0 and 2 request together; expect core0 to win.
- **Back-to-back writes:** core3 holds write `req` for 6 cycles.
  - Expect `gnt[3]` in cycles 1, 3 and 5.
  - Expect `busy` low in cycles 2 and 4.
